text_terminal_writer: RTL and testbench

Front-end of the 80x25 debug text display: consumes a byte stream (debug UART / BL616 link) and writes characters into the shared 2000-byte character buffer that the video generator scans. It owns the terminal state driven into the video generator: cursor position, cursor blink phase and `first_char`, the circular-buffer offset used for hardware scrolling. It decodes a minimal control-code set (CR, LF, BS, FF), wraps long lines, scrolls by moving `first_char`, and blank-fills rows with 0x20.

---
 rtl/text_terminal_writer.sv | 152 +++++++++++++++
 tb/tb_text_terminal_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_terminal_writer.sv
// rtl/text_terminal_writer.sv - byte stream to 80x25 character buffer writer with scroll and blink
module text_terminal_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_buf_we,
    output logic [10:0] o_buf_addr,
    output logic [7:0]  o_buf_wdata,
    output logic [6:0]  o_cursor_x,
    output logic [4:0]  o_cursor_y,
    output logic [10:0] o_first_char,
    output logic        o_cursor_blink_on
);
    localparam logic [11:0] BUF_SIZE  = 12'(COLS * ROWS);
    localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);
    localparam logic [10:0] ROW_STEP  = 11'(COLS);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam int          BW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t          r_state;
    logic [10:0]     r_line_base;
    logic [10:0]     r_clr_addr;
    logic [11:0]     r_clr_cnt;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_in_ready;
    logic            r_buf_we;
    logic [10:0]     r_buf_addr;
    logic [7:0]      r_buf_wdata;
    logic [6:0]      r_cursor_x;
    logic [4:0]      r_cursor_y;
    logic [10:0]     r_first_char;
    logic            r_blink;

    // Both operands are already below the buffer size, so one conditional subtract suffices.
    function automatic logic [10:0] f_wrap_add(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= BUF_SIZE)
            s = s - BUF_SIZE;
        return s[10:0];
    endfunction

    logic        w_accept;
    logic        w_printable;
    logic        w_newline;
    logic [10:0] w_next_base;
    logic [10:0] w_char_addr;

    assign w_accept    = i_in_valid & r_in_ready & (r_state == ST_IDLE);
    assign w_printable = (i_in_data >= 8'h20) && (i_in_data <= 8'h7E);
    assign w_newline   = (w_printable && (r_cursor_x == LAST_COL)) || (i_in_data == 8'h0A);
    assign w_next_base = f_wrap_add(r_line_base, ROW_STEP);
    assign w_char_addr = f_wrap_add(r_line_base, {4'b0000, r_cursor_x});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= 11'd0;
            r_clr_cnt    <= BUF_SIZE;
            r_line_base  <= 11'd0;
            r_in_ready   <= 1'b0;
            r_buf_we     <= 1'b0;
            r_buf_addr   <= 11'd0;
            r_buf_wdata  <= 8'h20;
            r_cursor_x   <= 7'd0;
            r_cursor_y   <= 5'd0;
            r_first_char <= 11'd0;
        end else begin
            r_buf_we <= 1'b0;
            if (r_state == ST_CLEAR) begin
                if (r_clr_cnt != 12'd0) begin
                    r_buf_we    <= 1'b1;
                    r_buf_addr  <= r_clr_addr;
                    r_buf_wdata <= 8'h20;
                    r_clr_addr  <= (r_clr_addr == LAST_ADDR) ? 11'd0 : r_clr_addr + 11'd1;
                    r_clr_cnt   <= r_clr_cnt - 12'd1;
                end else begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            end else if (w_accept) begin
                if (w_printable) begin
                    r_buf_we    <= 1'b1;
                    r_buf_addr  <= w_char_addr;
                    r_buf_wdata <= i_in_data;
                    if (r_cursor_x != LAST_COL)
                        r_cursor_x <= r_cursor_x + 7'd1;
                end else if (i_in_data == 8'h0D) begin
                    r_cursor_x <= 7'd0;
                end else if (i_in_data == 8'h08) begin
                    if (r_cursor_x != 7'd0)
                        r_cursor_x <= r_cursor_x - 7'd1;
                end else if (i_in_data == 8'h0C) begin
                    r_first_char <= 11'd0;
                    r_line_base  <= 11'd0;
                    r_cursor_x   <= 7'd0;
                    r_cursor_y   <= 5'd0;
                    r_clr_addr   <= 11'd0;
                    r_clr_cnt    <= BUF_SIZE;
                    r_state      <= ST_CLEAR;
                    r_in_ready   <= 1'b0;
                end

                // On the bottom row a newline scrolls by advancing first_char and blanks the new row.
                if (w_newline) begin
                    r_cursor_x  <= 7'd0;
                    r_line_base <= w_next_base;
                    if (r_cursor_y != LAST_ROW) begin
                        r_cursor_y <= r_cursor_y + 5'd1;
                    end else begin
                        r_first_char <= f_wrap_add(r_first_char, ROW_STEP);
                        r_clr_addr   <= w_next_base;
                        r_clr_cnt    <= 12'(COLS);
                        r_state      <= ST_CLEAR;
                        r_in_ready   <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign o_in_ready        = r_in_ready;
    assign o_buf_we          = r_buf_we;
    assign o_buf_addr        = r_buf_addr;
    assign o_buf_wdata       = r_buf_wdata;
    assign o_cursor_x        = r_cursor_x;
    assign o_cursor_y        = r_cursor_y;
    assign o_first_char      = r_first_char;
    assign o_cursor_blink_on = r_blink;
endmodule

// File: tb/tb_text_terminal_writer.sv
// tb/tb_text_terminal_writer.sv - randomized bench for text_terminal_writer against a behavioural terminal model
module tb_text_terminal_writer;
    localparam int BH = 37;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_data = 8'h00;
    logic        o_in_ready;
    logic        o_buf_we;
    logic [10:0] o_buf_addr;
    logic [7:0]  o_buf_wdata;
    logic [6:0]  o_cursor_x;
    logic [4:0]  o_cursor_y;
    logic [10:0] o_first_char;
    logic        o_cursor_blink_on;

    text_terminal_writer #(.COLS(80), .ROWS(25), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
        .o_cursor_x(o_cursor_x), .o_cursor_y(o_cursor_y), .o_first_char(o_first_char),
        .o_cursor_blink_on(o_cursor_blink_on)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: screen state as plain integers, pending blank-fill as an address queue.
    int  m_cx, m_cy, m_fc, m_cyc, m_addr, m_wdata;
    bit  m_ready, m_we, m_blink;
    int  clr_q[$];
    bit  chk_en = 1'b0;

    task automatic m_fill(input int base, input int n);
        for (int i = 0; i < n; i++) clr_q.push_back((base + i) % 2000);
        m_ready = 1'b0;
    endtask

    task automatic m_newline();
        m_cx = 0;
        if (m_cy < 24) m_cy++;
        else begin
            m_fc = (m_fc + 80) % 2000;
            m_fill((m_fc + 24 * 80) % 2000, 80);
        end
    endtask

    always @(posedge clk) begin
        int b;
        if (reset) begin
            m_cx = 0; m_cy = 0; m_fc = 0; m_cyc = 0; m_blink = 1'b0;
            m_we = 1'b0; m_addr = 0; m_wdata = 32;
            clr_q.delete();
            m_fill(0, 2000);
            chk_en = 1'b1;
        end else begin
            m_cyc++;
            m_blink = ((m_cyc / BH) % 2) == 1;
            m_we = 1'b0;
            if (clr_q.size() > 0) begin
                m_addr = clr_q.pop_front();
                m_wdata = 32;
                m_we = 1'b1;
            end else if (!m_ready) begin
                m_ready = 1'b1;
            end else if (i_in_valid) begin
                b = int'(i_in_data);
                if (b >= 32 && b <= 126) begin
                    m_we = 1'b1;
                    m_addr = (m_fc + m_cy * 80 + m_cx) % 2000;
                    m_wdata = b;
                    if (m_cx < 79) m_cx++;
                    else m_newline();
                end else if (b == 13) m_cx = 0;
                else if (b == 10) m_newline();
                else if (b == 8) begin
                    if (m_cx > 0) m_cx--;
                end else if (b == 12) begin
                    m_fc = 0; m_cx = 0; m_cy = 0;
                    m_fill(0, 2000);
                end
            end
        end
    end

    int wlog_a[$];
    int wlog_d[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(o_in_ready), int'(m_ready));
            chk("buf_we", int'(o_buf_we), int'(m_we));
            if (m_we) begin
                chk("buf_addr", int'(o_buf_addr), m_addr);
                chk("buf_wdata", int'(o_buf_wdata), m_wdata);
            end
            if (o_buf_we) begin
                chk("addr_range", int'(o_buf_addr < 11'd2000), 1);
                wlog_a.push_back(int'(o_buf_addr));
                wlog_d.push_back(int'(o_buf_wdata));
            end
            chk("cursor_x", int'(o_cursor_x), m_cx);
            chk("cursor_y", int'(o_cursor_y), m_cy);
            chk("first_char", int'(o_first_char), m_fc);
            chk("blink", int'(o_cursor_blink_on), int'(m_blink));
        end
    end

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!o_in_ready && n < 2500) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: in_ready still %0d after %0d cycles, required 1", o_in_ready, n);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        i_in_valid = 1'b1;
        i_in_data = b;
        n = 0;
        while (!o_in_ready && n < 2500) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready %0d, required 1", o_in_ready);
            i_in_valid = 1'b0;
        end else begin
            @(negedge clk);
            i_in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(o_in_ready), 0);
        chk("rst_we", int'(o_buf_we), 0);
        chk("rst_wdata", int'(o_buf_wdata), 32);
        chk("rst_addr", int'(o_buf_addr), 0);
        chk("rst_fc", int'(o_first_char), 0);
        clear_log();
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n, blanks;
        int r;
        logic [7:0] b;

        do_reset();
        wait_ready(n);
        chk("reset_ready_cycle", n, 2001);
        chk("reset_clear_count", wlog_a.size(), 2000);
        blanks = 0;
        for (int i = 0; i < wlog_a.size(); i++)
            if (wlog_a[i] == i && wlog_d[i] == 32) blanks++;
        chk("reset_clear_ordered", blanks, 2000);

        clear_log();
        send(8'h41);
        send(8'h42);
        idle(1);
        chk("ab_count", wlog_a.size(), 2);
        if (wlog_a.size() == 2) begin
            chk("a_addr", wlog_a[0], 0);
            chk("a_data", wlog_d[0], 8'h41);
            chk("b_addr", wlog_a[1], 1);
            chk("b_data", wlog_d[1], 8'h42);
        end
        chk("ab_cx", int'(o_cursor_x), 2);

        clear_log();
        send(8'h08);
        idle(1);
        chk("bs1_cx", int'(o_cursor_x), 1);
        send(8'h08);
        send(8'h08);
        idle(1);
        chk("bs3_cx", int'(o_cursor_x), 0);
        chk("bs_no_write", wlog_a.size(), 0);

        clear_log();
        repeat (80) send(8'h78);
        idle(1);
        chk("row_count", wlog_a.size(), 80);
        if (wlog_a.size() == 80) chk("row_last_addr", wlog_a[79], 79);
        chk("wrap_cx", int'(o_cursor_x), 0);
        chk("wrap_cy", int'(o_cursor_y), 1);
        chk("wrap_fc", int'(o_first_char), 0);
        chk("wrap_no_clear", int'(o_in_ready), 1);

        clear_log();
        send(8'h0C);
        chk("ff_cx", int'(o_cursor_x), 0);
        chk("ff_cy", int'(o_cursor_y), 0);
        chk("ff_fc", int'(o_first_char), 0);
        wait_ready(n);
        chk("ff_ready_gap", n, 2001);
        chk("ff_clear_count", wlog_a.size(), 2000);

        repeat (24) send(8'h0A);
        clear_log();
        send(8'h5A);
        idle(1);
        chk("z_cy", int'(o_cursor_y), 24);
        chk("z_cx", int'(o_cursor_x), 1);
        if (wlog_a.size() == 1) chk("z_addr", wlog_a[0], 1920);
        else chk("z_count", wlog_a.size(), 1);

        clear_log();
        send(8'h0A);
        chk("scroll_fc", int'(o_first_char), 80);
        chk("scroll_cy", int'(o_cursor_y), 24);
        wait_ready(n);
        chk("scroll_ready_gap", n, 81);
        chk("scroll_clear_count", wlog_a.size(), 80);
        if (wlog_a.size() == 80) begin
            chk("scroll_first", wlog_a[0], 0);
            chk("scroll_last", wlog_a[79], 79);
        end

        repeat (23) send(8'h0A);
        wait_ready(n);
        chk("fc_1920", int'(o_first_char), 1920);
        for (int i = 0; i < 25; i++) begin
            send(8'h0A);
            if (i == 0) chk("fc_wrap0", int'(o_first_char), 0);
        end
        wait_ready(n);
        chk("fc_after25", int'(o_first_char), 1920);

        clear_log();
        send(8'h07);
        send(8'h7F);
        send(8'h1B);
        idle(1);
        chk("ign_no_write", wlog_a.size(), 0);
        chk("ign_cx", int'(o_cursor_x), 0);
        chk("ign_cy", int'(o_cursor_y), 24);

        send(8'h0C);
        idle(500);
        do_reset();
        idle(3);
        if (wlog_a.size() > 0) begin
            chk("rst_restart_addr", wlog_a[0], 0);
            chk("rst_restart_data", wlog_d[0], 32);
        end else chk("rst_restart_count", wlog_a.size(), 3);
        wait_ready(n);

        for (int it = 0; it < 2000; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60) b = 8'($urandom_range(32, 126));
            else if (r < 68) b = 8'h0D;
            else if (r < 73) b = 8'h0A;
            else if (r < 80) b = 8'h08;
            else if (r < 81) b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h41;
            else b = 8'($urandom_range(0, 255));
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (it == 1000) begin
                do_reset();
                wait_ready(n);
            end
        end
        idle(2);
        wait_ready(n);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
